// File: rtl/mips_pc_pkg.sv
// Shared PC constants and fetch-state encoding, used by IF and by the ID next-PC mux.
package mips_pc_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;

    localparam logic [AW-1:0] PC_RESET = 32'h8000_0000;
    localparam logic [AW-1:0] ILLOP    = 32'h8000_0004;
    localparam logic [AW-1:0] XADR     = 32'h8000_0008;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } fetch_state_e;

    // Word-alignment test on the two low address bits.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and memory (slave).
interface if_fetch_unit_if #(
    parameter int unsigned AW = mips_pc_pkg::AW,
    parameter int unsigned IW = mips_pc_pkg::IW
);
    logic          ImemReq;
    logic [AW-1:0] ImemAddr;
    logic          ImemAck;
    logic [IW-1:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemRdata
    );
endinterface

// File: rtl/if_fetch_unit_pc_reg.sv
// Architectural PC register: async active-low reset to a fixed vector, load-enable update.
module pc_reg #(
    parameter int unsigned    W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over req/ack,
// and handles stall, redirect, misaligned targets and kernel-masked IRQ qualification.
module if_fetch_unit #(
    parameter int unsigned   AW       = mips_pc_pkg::AW,
    parameter logic [AW-1:0] PC_RESET = AW'(mips_pc_pkg::PC_RESET)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [AW-1:0]             NewPC,
    input  logic                      IdReady,
    input  logic                      Flush,
    input  logic [AW-1:0]             FlushPC,
    input  logic                      IRQ,
    if_fetch_unit_if.master           imem,
    output logic [AW-1:0]             PC,
    output logic [AW-1:0]             PCPlus4,
    output logic [mips_pc_pkg::IW-1:0] Instruction,
    output logic                      InstValid,
    output logic                      AddrErr,
    output logic                      IRQPending
);
    import mips_pc_pkg::IW;
    import mips_pc_pkg::fetch_state_e;
    import mips_pc_pkg::FETCH;
    import mips_pc_pkg::HOLD;
    import mips_pc_pkg::ERR;
    import mips_pc_pkg::is_misaligned;

    fetch_state_e  state_q, state_d;
    logic          req_q, req_d;
    logic          guard_q;
    logic          redir_pend_q, redir_pend_d;
    logic [AW-1:0] redir_pc_q, redir_pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          irq_q, irq_d;

    logic          pc_load;
    logic [AW-1:0] pc_d, pc_q;
    logic          gap;
    logic          ack_ok;

    pc_reg #(
        .W         (AW),
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (reset),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc_q)
    );

    // An ack only counts against a request we actually issued after the post-reset guard.
    assign ack_ok = imem.ImemAck & req_q & ~guard_q;

    always_comb begin
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        instr_d      = instr_q;
        pc_load      = 1'b0;
        pc_d         = pc_q;
        gap          = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (!req_q) begin
                    // No transaction on the bus (guard or gap cycle): redirect directly.
                    if (Flush) begin
                        pc_load = 1'b1;
                        pc_d    = FlushPC;
                    end
                end else if (ack_ok) begin
                    if (redir_pend_q || Flush) begin
                        pc_load      = 1'b1;
                        pc_d         = Flush ? FlushPC : redir_pc_q;
                        redir_pend_d = 1'b0;
                        gap          = 1'b1;
                    end else begin
                        instr_d = imem.ImemRdata;
                        state_d = HOLD;
                    end
                end else if (Flush) begin
                    // Keep the outstanding request intact; remember where to go afterwards.
                    redir_pend_d = 1'b1;
                    redir_pc_d   = FlushPC;
                end
            end
            HOLD: begin
                if (Flush) begin
                    pc_load = 1'b1;
                    pc_d    = FlushPC;
                end else if (IdReady) begin
                    pc_load = 1'b1;
                    pc_d    = NewPC;
                end
            end
            ERR: begin
                if (Flush) begin
                    pc_load = 1'b1;
                    pc_d    = FlushPC;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Every PC load restarts fetch, or parks in ERR if the target is not word aligned.
        if (pc_load) begin
            state_d = is_misaligned(pc_d[1:0]) ? ERR : FETCH;
        end
    end

    assign req_d   = (state_d == FETCH) & ~gap;
    assign valid_d = (state_d == HOLD);
    assign err_d   = (state_d == ERR);
    assign irq_d   = IRQ & ~pc_q[AW-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            req_q        <= 1'b0;
            guard_q      <= 1'b1;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            guard_q      <= 1'b0;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            irq_q        <= irq_d;
        end
    end

    assign imem.ImemReq  = req_q;
    assign imem.ImemAddr = pc_q;
    assign PC            = pc_q;
    assign PCPlus4       = pc_q + AW'(4);
    assign Instruction   = instr_q;
    assign InstValid     = valid_q;
    assign AddrErr       = err_q;
    assign IRQPending    = irq_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, reset corner sequence, and random run
// against a behavioural fetch model.
module tb_if_fetch_unit;
    import mips_pc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] new_pc, flush_pc;
    logic        id_ready, flush, irq;
    logic [31:0] pc, pc_plus4, instruction;
    logic        inst_valid, addr_err, irq_pending;

    int n_chk = 0;
    int n_err = 0;

    if_fetch_unit_if imem ();

    if_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .NewPC       (new_pc),
        .IdReady     (id_ready),
        .Flush       (flush),
        .FlushPC     (flush_pc),
        .IRQ         (irq),
        .imem        (imem),
        .PC          (pc),
        .PCPlus4     (pc_plus4),
        .Instruction (instruction),
        .InstValid   (inst_valid),
        .AddrErr     (addr_err),
        .IRQPending  (irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [31:0] fp;
        logic        ir;
        logic [31:0] np;
        logic        ak;
        logic [31:0] rd;
        logic        iq;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_err;
        logic        e_irqp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic [31:0] fp, input logic ir,
                                input logic [31:0] np, input logic ak, input logic [31:0] rd,
                                input logic iq, input logic e_req, input logic [31:0] e_pc,
                                input logic e_valid, input logic [31:0] e_inst,
                                input logic e_err, input logic e_irqp);
        vec_t v;
        v.fl = fl; v.fp = fp; v.ir = ir; v.np = np; v.ak = ak; v.rd = rd; v.iq = iq;
        v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid; v.e_inst = e_inst;
        v.e_err = e_err; v.e_irqp = e_irqp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_pc,
                              input logic e_valid, input logic [31:0] e_inst,
                              input logic e_err, input logic e_irqp);
        chk({tag, ".ImemReq"},     32'(imem.ImemReq), 32'(e_req));
        chk({tag, ".ImemAddr"},    imem.ImemAddr,     e_pc);
        chk({tag, ".PC"},          pc,                e_pc);
        chk({tag, ".PCPlus4"},     pc_plus4,          e_pc + 32'd4);
        chk({tag, ".InstValid"},   32'(inst_valid),   32'(e_valid));
        chk({tag, ".Instruction"}, instruction,       e_inst);
        chk({tag, ".AddrErr"},     32'(addr_err),     32'(e_err));
        chk({tag, ".IRQPending"},  32'(irq_pending),  32'(e_irqp));
    endtask

    task automatic drive(input logic fl, input logic [31:0] fp, input logic ir,
                         input logic [31:0] np, input logic ak, input logic [31:0] rd,
                         input logic iq);
        flush = fl; flush_pc = fp; id_ready = ir; new_pc = np;
        imem.ImemAck = ak; imem.ImemRdata = rd; irq = iq;
    endtask

    // Behavioural model: what ID should see, tracked as plain flags plus a redirect queue.
    logic [31:0] m_pc, m_inst;
    bit          m_valid, m_err, m_req, m_irqp;
    logic [31:0] m_redir[$];

    task automatic model_reset();
        m_pc = PC_RESET; m_inst = '0;
        m_valid = 0; m_err = 0; m_req = 0; m_irqp = 0;
        m_redir.delete();
    endtask

    task automatic model_step(input logic fl, input logic [31:0] fp, input logic ir,
                              input logic [31:0] np, input logic ak, input logic [31:0] rd,
                              input logic iq);
        bit          load = 0, gap = 0, got = 0;
        logic [31:0] tgt = m_pc;
        bit          irqp_n = iq && (m_pc < 32'h8000_0000);
        if (m_err || m_valid) begin
            if (fl) begin load = 1; tgt = fp; end
            else if (m_valid && ir) begin load = 1; tgt = np; end
        end else if (!m_req) begin
            if (fl) begin load = 1; tgt = fp; end
        end else if (ak) begin
            if (fl || m_redir.size() != 0) begin
                tgt = fl ? fp : m_redir[0];
                m_redir.delete();
                load = 1; gap = 1;
            end else begin
                got = 1; m_inst = rd;
            end
        end else if (fl) begin
            m_redir.delete();
            m_redir.push_back(fp);
        end
        if (load) begin
            m_pc = tgt; m_err = (tgt % 4) != 0; m_valid = 0;
        end else if (got) begin
            m_valid = 1;
        end
        m_req  = !m_valid && !m_err && !gap;
        m_irqp = irqp_n;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom % 8)
            0:       return ILLOP;
            1:       return XADR;
            2:       return $urandom;
            default: return $urandom & 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Directed vectors, applied from reset release; each row shows the state after one edge.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    1, 32'h8000_0000, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h2408_0001, 0,        0, 32'h8000_0000, 1, 32'h2408_0001, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,                0, 32'h8000_0000, 1, 32'h2408_0001, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0040_0010, 0, 0, 0,        1, 32'h0040_0010, 0, 32'h2408_0001, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,                    1, 32'h0040_0010, 0, 32'h2408_0001, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h3C01_1234, 0,        0, 32'h0040_0010, 1, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0040_0002, 0, 0, 0,        0, 32'h0040_0002, 0, 32'h3C01_1234, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,                    0, 32'h0040_0002, 0, 32'h3C01_1234, 1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0, 0, 0, 0,                0, 32'h0040_0002, 0, 32'h3C01_1234, 1, 0));
        vecs.push_back(mk(1, ILLOP, 0, 0, 0, 0, 0,                1, 32'h8000_0004, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(1, XADR, 0, 0, 0, 0, 0,                 1, 32'h8000_0004, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    1, 32'h8000_0004, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    1, 32'h8000_0004, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h1111_1111, 0,        0, 32'h8000_0008, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    1, 32'h8000_0008, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0010, 0, 0, 1, 32'h2222_2222, 0, 0, 32'h8000_0010, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,                    1, 32'h8000_0010, 0, 32'h3C01_1234, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h3333_3333, 0,        0, 32'h8000_0010, 1, 32'h3333_3333, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0001, 1, 32'h0040_0000, 0, 0, 0, 0, 32'h8000_0001, 0, 32'h3333_3333, 1, 0));
        vecs.push_back(mk(1, 32'h8000_0003, 0, 0, 0, 0, 0,        0, 32'h8000_0003, 0, 32'h3333_3333, 1, 0));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0,        1, 32'hFFFF_FFFC, 0, 32'h3333_3333, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 1,                0, 32'hFFFF_FFFC, 1, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0040_0000, 0, 0, 0,        1, 32'h0040_0000, 0, 32'h0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_outs("in_reset", 0, PC_RESET, 0, 32'h0, 0, 0);
        reset = 1'b1;
        #1;
        check_outs("released", 0, PC_RESET, 0, 32'h0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].fp, vecs[i].ir, vecs[i].np, vecs[i].ak, vecs[i].rd, vecs[i].iq);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_valid,
                       vecs[i].e_inst, vecs[i].e_err, vecs[i].e_irqp);
        end

        // Reset mid-request, with a stale ack held across reset and the release edge.
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_outs("midrst", 0, PC_RESET, 0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outs("stale_ack", 1, PC_RESET, 0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("post_rst_wait", 1, PC_RESET, 0, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h1234_5678, 0);
        @(posedge clk);
        #1;
        check_outs("post_rst_fetch", 0, PC_RESET, 1, 32'h1234_5678, 0, 0);

        // Random traffic against the behavioural model.
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            logic        fl, ir, ak, iq;
            logic [31:0] fp, np, rd;
            fl = ($urandom % 8) == 0;
            fp = pick_target();
            ir = ($urandom % 2) == 0;
            np = pick_target();
            ak = m_req && (($urandom % 3) == 0);
            rd = $urandom;
            iq = ($urandom % 2) == 0;
            drive(fl, fp, ir, np, ak, rd, iq);
            @(posedge clk);
            model_step(fl, fp, ir, np, ak, rd, iq);
            #1;
            check_outs($sformatf("rnd%0d", c), m_req, m_pc, m_valid, m_inst, m_err, m_irqp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
